// File: rtl/core_bus_arbiter_pkg.sv
// Shared i2d core bus types and arbiter state encoding.
package i2d_core_defines;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [3:0]        wb_sel_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_IF,
    ARB_GNT_DM
  } arb_state_t;

endpackage

// File: rtl/core_arb_watchdog.sv
// Saturating no-response counter; fire flags a stalled strobe at TIMEOUT cycles.
module core_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic fire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Saturates at LIMIT so a held strobe can never wrap back to a quiet count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign fire = (TIMEOUT != 0) && run && (count == LIMIT);

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-master Wishbone arbiter: DM has priority, IF yields at its next completed beat.
module core_bus_arbiter
  import i2d_core_defines::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_cyc,
  input  logic          if_stb,
  input  logic          if_we,
  input  logic [3:0]    if_sel,
  input  logic [AW-1:0] if_adr,
  input  logic [DW-1:0] if_dat_mo,
  output logic          if_ack,
  output logic          if_err,
  input  logic          dm_cyc,
  input  logic          dm_stb,
  input  logic          dm_we,
  input  logic [3:0]    dm_sel,
  input  logic [AW-1:0] dm_adr,
  input  logic [DW-1:0] dm_dat_mo,
  output logic          dm_ack,
  output logic          dm_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [3:0]    s_sel,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_mo,
  input  logic          s_ack,
  input  logic          s_err,
  input  logic [DW-1:0] s_dat_so,
  output logic [DW-1:0] rd_dat,
  output logic [1:0]    grant,
  output logic          arb_timeout
);

  // Handshake: a beat is offered while s_cyc & s_stb are high and completes on
  // the cycle s_ack or s_err (or a watchdog timeout) is seen; one beat in flight.

  arb_state_t state, state_nxt;
  logic       resp, wd_fire, timeout, done, wd_clr, wd_run;

  assign resp    = s_ack | s_err;
  assign timeout = wd_fire & ~resp;
  assign done    = resp | timeout;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (dm_cyc)      state_nxt = ARB_GNT_DM;
        else if (if_cyc) state_nxt = ARB_GNT_IF;
      end
      ARB_GNT_IF: begin
        if (!if_cyc)             state_nxt = dm_cyc ? ARB_GNT_DM : ARB_IDLE;
        else if (dm_cyc && done) state_nxt = ARB_GNT_DM;
      end
      ARB_GNT_DM: begin
        if (!dm_cyc) state_nxt = if_cyc ? ARB_GNT_IF : ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  assign grant = {state == ARB_GNT_DM, state == ARB_GNT_IF};

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_adr    = '0;
    s_dat_mo = '0;
    if_ack   = 1'b0;
    if_err   = 1'b0;
    dm_ack   = 1'b0;
    dm_err   = 1'b0;
    case (state)
      ARB_GNT_IF: begin
        s_cyc    = if_cyc;
        s_stb    = if_stb;
        s_we     = if_we;
        s_sel    = if_sel;
        s_adr    = if_adr;
        s_dat_mo = if_dat_mo;
        if_ack   = s_ack;
        if_err   = s_err | timeout;
      end
      ARB_GNT_DM: begin
        s_cyc    = dm_cyc;
        s_stb    = dm_stb;
        s_we     = dm_we;
        s_sel    = dm_sel;
        s_adr    = dm_adr;
        s_dat_mo = dm_dat_mo;
        dm_ack   = s_ack;
        dm_err   = s_err | timeout;
      end
      default: ;
    endcase
  end

  assign rd_dat      = s_dat_so;
  assign arb_timeout = timeout;

  // A forced timeout counts as a completed beat so a held strobe rearms the count.
  assign wd_run = (state != ARB_IDLE) && s_stb;
  assign wd_clr = (state_nxt != state) || done || !s_stb;

  core_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .run  (wd_run),
    .fire (wd_fire)
  );

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with a short watchdog (TIMEOUT=4).
module tb_core_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          if_cyc, if_stb, if_we;
  logic [3:0]    if_sel;
  logic [AW-1:0] if_adr;
  logic [DW-1:0] if_dat_mo;
  logic          if_ack, if_err;
  logic          dm_cyc, dm_stb, dm_we;
  logic [3:0]    dm_sel;
  logic [AW-1:0] dm_adr;
  logic [DW-1:0] dm_dat_mo;
  logic          dm_ack, dm_err;
  logic          s_cyc, s_stb, s_we;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_mo;
  logic          s_ack, s_err;
  logic [DW-1:0] s_dat_so;
  logic [DW-1:0] rd_dat;
  logic [1:0]    grant;
  logic          arb_timeout;

  int checks = 0;
  int errors = 0;

  core_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_cyc(if_cyc), .if_stb(if_stb), .if_we(if_we), .if_sel(if_sel),
    .if_adr(if_adr), .if_dat_mo(if_dat_mo), .if_ack(if_ack), .if_err(if_err),
    .dm_cyc(dm_cyc), .dm_stb(dm_stb), .dm_we(dm_we), .dm_sel(dm_sel),
    .dm_adr(dm_adr), .dm_dat_mo(dm_dat_mo), .dm_ack(dm_ack), .dm_err(dm_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_mo(s_dat_mo), .s_ack(s_ack), .s_err(s_err),
    .s_dat_so(s_dat_so), .rd_dat(rd_dat), .grant(grant), .arb_timeout(arb_timeout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change #1 after the edge, checks follow a further #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_masters();
    if_cyc = 0; if_stb = 0; if_we = 0; if_sel = '0; if_adr = '0; if_dat_mo = '0;
    dm_cyc = 0; dm_stb = 0; dm_we = 0; dm_sel = '0; dm_adr = '0; dm_dat_mo = '0;
  endtask

  initial begin
    rst = 0;
    idle_masters();
    s_ack = 0; s_err = 0; s_dat_so = 32'hCAFE_0001;
    repeat (2) step();
    settle();
    check_eq("reset_grant", grant, 2'b00);
    check_eq("reset_s_cyc", s_cyc, 1'b0);
    check_eq("reset_timeout", arb_timeout, 1'b0);
    rst = 1;
    step();

    // IF alone, slave acking every cycle
    if_cyc = 1; if_stb = 1; if_adr = 32'h100; if_sel = 4'hF; s_ack = 1;
    settle();
    check_eq("idle_s_adr", s_adr, 32'h0);
    check_eq("idle_if_ack", if_ack, 1'b0);
    step();
    settle();
    check_eq("if_grant", grant, 2'b01);
    check_eq("if_s_adr", s_adr, 32'h100);
    check_eq("if_ack", if_ack, 1'b1);
    check_eq("if_dm_ack", dm_ack, 1'b0);
    check_eq("rd_dat", rd_dat, 32'hCAFE_0001);
    if_adr = 32'h104;
    settle();
    check_eq("if_s_adr_track", s_adr, 32'h104);

    // Simultaneous request from idle: DM first, then IF with no idle gap
    idle_masters(); s_ack = 0;
    step();
    settle();
    check_eq("back_idle", grant, 2'b00);
    if_cyc = 1; if_stb = 1; if_adr = 32'h200;
    dm_cyc = 1; dm_stb = 1; dm_adr = 32'h300; s_ack = 1;
    step();
    settle();
    check_eq("both_grant_dm", grant, 2'b10);
    check_eq("both_s_adr", s_adr, 32'h300);
    check_eq("both_dm_ack", dm_ack, 1'b1);
    check_eq("both_if_ack", if_ack, 1'b0);
    dm_cyc = 0; dm_stb = 0;
    step();
    settle();
    check_eq("dm_drop_grant_if", grant, 2'b01);
    check_eq("dm_drop_s_adr", s_adr, 32'h200);

    // Pre-emption of streaming IF at its next completed beat
    s_ack = 0;
    dm_cyc = 1; dm_stb = 1; dm_we = 1; dm_adr = 32'h2000; dm_dat_mo = 32'hDEADBEEF; dm_sel = 4'hF;
    step();
    settle();
    check_eq("preempt_wait_grant", grant, 2'b01);
    check_eq("preempt_wait_s_adr", s_adr, 32'h200);
    s_ack = 1;
    settle();
    check_eq("preempt_if_beat_ack", if_ack, 1'b1);
    check_eq("preempt_dm_ack_pre", dm_ack, 1'b0);
    step();
    settle();
    check_eq("preempt_grant_dm", grant, 2'b10);
    check_eq("preempt_if_stall", if_ack, 1'b0);
    check_eq("preempt_s_adr", s_adr, 32'h2000);
    check_eq("preempt_s_dat", s_dat_mo, 32'hDEADBEEF);
    check_eq("preempt_s_sel", s_sel, 4'hF);
    check_eq("preempt_s_we", s_we, 1'b1);
    check_eq("preempt_dm_ack", dm_ack, 1'b1);
    step();
    settle();
    check_eq("dm_not_preempted", grant, 2'b10);
    check_eq("if_still_stalled", if_ack, 1'b0);
    idle_masters(); s_ack = 0;
    step();

    // Silent slave on a DM beat: err pulse after 4 stalled cycles
    dm_cyc = 1; dm_stb = 1; dm_adr = 32'h400;
    step();
    settle();
    check_eq("wd_grant", grant, 2'b10);
    for (int i = 0; i < 4; i++) begin
      check_eq("wd_quiet_err", dm_err, 1'b0);
      check_eq("wd_quiet_to", arb_timeout, 1'b0);
      step();
      settle();
    end
    check_eq("wd_fire_err", dm_err, 1'b1);
    check_eq("wd_fire_to", arb_timeout, 1'b1);
    check_eq("wd_fire_if_err", if_err, 1'b0);
    check_eq("wd_fire_dm_ack", dm_ack, 1'b0);
    step();
    settle();
    check_eq("wd_pulse_end_err", dm_err, 1'b0);
    check_eq("wd_pulse_end_to", arb_timeout, 1'b0);
    check_eq("wd_keep_grant", grant, 2'b10);
    idle_masters();
    step();

    // Same setup with ack landing on the timeout cycle: ack wins
    dm_cyc = 1; dm_stb = 1; dm_adr = 32'h500;
    repeat (5) step();
    s_ack = 1;
    settle();
    check_eq("race_dm_ack", dm_ack, 1'b1);
    check_eq("race_dm_err", dm_err, 1'b0);
    check_eq("race_to", arb_timeout, 1'b0);
    s_ack = 0;
    step();

    // Asynchronous reset in the middle of a DM grant
    settle();
    check_eq("pre_rst_s_cyc", s_cyc, 1'b1);
    rst = 0;
    settle();
    check_eq("rst_s_cyc", s_cyc, 1'b0);
    check_eq("rst_grant", grant, 2'b00);
    idle_masters();
    step();
    rst = 1;
    if_cyc = 1; if_stb = 1; if_adr = 32'h600;
    settle();
    check_eq("post_rst_idle", grant, 2'b00);
    step();
    settle();
    check_eq("post_rst_grant_if", grant, 2'b01);
    check_eq("post_rst_s_adr", s_adr, 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
